// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu block.
//   - Base ALU op codes (4-bit, op[4]=0) and M-extension funct3 codes (op[4]=1).
//   - FSM state encoding used by the top level.
//   - XLEN legality helper used at elaboration time.
package alu_pkg;

  // Base ops: op[3:0] when op[4]==0.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  // M ops: op[2:0] (RISC-V funct3) when op[4]==1.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per clock.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : load operands; the first quotient bit is produced on this edge
//   i_abort       : drop the division in progress (synchronous)
//   i_dividend    : unsigned dividend
//   i_divisor     : unsigned divisor (never zero; zero is handled by the caller)
//   o_busy        : iterations still outstanding
//   o_done        : one-cycle pulse after the last iteration
//   o_quotient    : quotient, valid while o_done is high
//   o_remainder   : remainder, valid while o_done is high
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  // The start edge already performs one step, so XLEN-1 remain.
  localparam logic [CNT_W-1:0] CNT_REST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // One restoring step, fed from the inputs on start and from the registers after.
  logic [XLEN-1:0] w_rem_in;
  logic [XLEN-1:0] w_quo_in;
  logic [XLEN-1:0] w_dvs_in;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  assign w_rem_in  = i_start ? '0 : r_rem;
  assign w_quo_in  = i_start ? i_dividend : r_quo;
  assign w_dvs_in  = i_start ? i_divisor : r_dvs;
  assign w_shift   = {w_rem_in, w_quo_in[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, w_dvs_in};
  // Partial remainder stays below the divisor, so a borrow lands exactly in the top bit.
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {w_quo_in[XLEN-2:0], w_ge};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_dvs  <= i_divisor;
      r_cnt  <= CNT_REST;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_cnt != '0) begin
        r_quo  <= w_quo_nxt;
        r_rem  <= w_rem_nxt;
        r_cnt  <= r_cnt - CNT_W'(1);
        r_done <= (r_cnt == CNT_W'(1));
      end
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle integer ALU with RV32M/RV64M multiply/divide behind valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort; beats accept and out_ready in the same cycle
//   in_valid   : request;  in_ready : idle and able to accept
//   op         : op[4]=0 base op (op[3:0]), op[4]=1 M op (op[2:0]=funct3)
//   a, b       : operands, sampled only in the accept cycle
//   out_valid  : result available;  out_ready : consumer takes the result
//   result     : held stable until out_ready
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("alu_mdu: XLEN must be 32 or 64");
  end

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_result_nxt;

  // Operands kept for the multiply cycle and sign info for the divide fix-up.
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_mul_op;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_is_rem;

  logic w_accept;
  assign w_accept = in_valid && (r_state == IDLE) && !flush;

  // ---------------- base ALU (evaluated on the live operands) ----------------
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_base;
  assign w_shamt = b[SHAMT_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_base = '0;
    case (op[3:0])
      OP_ADD:  w_base = a + b;
      OP_SUB:  w_base = a - b;
      OP_SLL:  w_base = a << w_shamt;
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  w_base = a ^ b;
      OP_SRL:  w_base = a >> w_shamt;
      OP_SRA:  w_base = XLEN'($signed(a) >>> w_shamt);
      OP_OR:   w_base = a | b;
      OP_AND:  w_base = a & b;
      default: w_base = '0;
    endcase
  end

  // ---------------- divide: special cases and magnitudes ----------------
  logic            w_div_signed;
  logic            w_b_zero;
  logic            w_overflow;
  logic            w_div_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  assign w_div_signed  = !op[0];
  assign w_b_zero      = (b == '0);
  assign w_overflow    = w_div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  assign w_div_special = w_b_zero || w_overflow;
  // op[1] selects REM/REMU over DIV/DIVU.
  assign w_special_res = w_b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  assign w_a_neg       = w_div_signed && a[XLEN-1];
  assign w_b_neg       = w_div_signed && b[XLEN-1];
  assign w_a_mag       = w_a_neg ? -a : a;
  assign w_b_mag       = w_b_neg ? -b : b;

  logic            w_div_start;
  logic            w_div_busy;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_q;
  logic [XLEN-1:0] w_div_r;

  assign w_div_start = w_accept && op[4] && op[2] && !w_div_special;

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_abort    (flush),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_q),
    .o_remainder(w_div_r)
  );

  // The done pulse only follows the final iteration, when busy has already dropped.
  logic            w_div_fin;
  logic [XLEN-1:0] w_div_res;
  assign w_div_fin = w_div_done && !w_div_busy;
  assign w_div_res = r_is_rem ? (r_r_neg ? -w_div_r : w_div_r)
                              : (r_q_neg ? -w_div_q : w_div_q);

  // ---------------- multiply ----------------
  logic              w_mul_a_sgn;
  logic              w_mul_b_sgn;
  logic [2*XLEN-1:0] w_mul_ax;
  logic [2*XLEN-1:0] w_mul_bx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  // MUL and MULH treat both signed; MULHSU only a; MULHU neither.
  assign w_mul_a_sgn = (r_mul_op != 2'b11);
  assign w_mul_b_sgn = !r_mul_op[1];
  assign w_mul_ax    = {{XLEN{w_mul_a_sgn && r_a[XLEN-1]}}, r_a};
  assign w_mul_bx    = {{XLEN{w_mul_b_sgn && r_b[XLEN-1]}}, r_b};
  assign w_prod      = w_mul_ax * w_mul_bx;
  assign w_mul_res   = (r_mul_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------- FSM ----------------
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (!op[4]) begin
              w_result_nxt = w_base;
              w_state_nxt  = DONE;
            end else if (!op[2]) begin
              w_state_nxt = MUL;
            end else if (w_div_special) begin
              w_result_nxt = w_special_res;
              w_state_nxt  = DONE;
            end else begin
              w_state_nxt = DIV;
            end
          end
        end
        MUL: begin
          w_result_nxt = w_mul_res;
          w_state_nxt  = DONE;
        end
        DIV: begin
          if (w_div_fin) begin
            w_result_nxt = w_div_res;
            w_state_nxt  = DONE;
          end
        end
        DONE: begin
          if (out_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mul_op <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_is_rem <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_mul_op <= op[1:0];
        r_q_neg  <= w_a_neg ^ w_b_neg;
        r_r_neg  <= w_a_neg;
        r_is_rem <= op[1];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the pipeline's combinational integer ALU. It executes the RV32I/RV64I base ALU operations plus the full M-extension: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU. Division uses an iterative restoring divider. The block sits in the EX stage behind a valid/ready handshake. It holds one operation in flight, and the hazard unit stalls on `in_ready`.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `SHAMT_W`, default $clog2(XLEN): shift-amount bits taken from `b`.
- `clk` (in, 1): the single clock.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `flush` (in, 1): synchronous abort of the in-flight operation.
- `in_valid` (in, 1): operation request.
- `in_ready` (out, 1): block can accept a request.
- `op` (in, 5): operation code.
  - `op[4]=0`: base op, using the 4-bit encodings ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - `op[4]=1`: M op, with `op[2:0]` = RISC-V funct3 (MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111).
- `a`, `b` (in, XLEN each): operands.
- `out_valid` (out, 1): result available.
- `out_ready` (in, 1): consumer accepts the result.
- `result` (out, XLEN): result, held stable while `out_valid && !out_ready`.

## Operation
- **States:** IDLE, MUL, DIV, DONE. `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`.
- **Accept:** a request is accepted when `in_valid && in_ready`. On accept, `op`, `a` and `b` are captured.
- **From IDLE on accept:**
  - Base op: compute the result and go to DONE.
  - MUL family: go to MUL.
  - DIV family, normal operands: go to DIV.
  - DIV family, special case: write the special result and go directly to DONE.
- **MUL:** one cycle.
  - Forms the 2·XLEN product; operands are sign-extended per op (MULHSU: `a` signed, `b` unsigned).
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - Then goes to DONE.
- **DIV:** XLEN iterations, one quotient bit per cycle, on magnitudes.
  - Signed ops negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Then goes to DONE.
- **Special cases,** detected at accept:
  - `b==0`: DIV/DIVU return all-ones; REM/REMU return `a`.
  - Signed overflow (`a`=most-negative, `b`=−1): DIV returns `a`; REM returns 0.
- **DONE → IDLE** when `out_ready`. `result` holds until then.
- **Shifts:** use only `b[SHAMT_W-1:0]`. SRA is arithmetic.
- **SLT/SLTU:** result is zero-extended 0 or 1.
- **Reserved codes:** undefined `op` values are treated as a base op with result 0.
- **flush:**
  - Wins over every other event in the same cycle, including accept and `out_ready`.
  - State goes to IDLE on the next edge, so `out_valid` is 0 the cycle after flush.
  - No request is accepted in the flush cycle.
- **Async reset:** mid-operation it behaves identically to flush, without waiting for a clock edge.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `result`=0, state=IDLE, divider registers=0.
- **Latency,** from the accept edge to `out_valid` high:
  - Base op and DIV special cases: 1 cycle.
  - MUL family: 2 cycles.
  - DIV family: XLEN+1 cycles (33 at XLEN=32).
- **Throughput:** one operation per (latency + 1) cycles when `out_ready` is held high. The DONE→IDLE cycle is never skipped.
- **Combinational paths:** `in_ready` and `out_valid` are register-decoded only. There is no path from `in_valid` to `in_ready`, nor from `out_ready` to `out_valid`.
- **Operand stability:** `a`, `b` and `op` need only be stable in the accept cycle.

## Structure
- **Package `alu_pkg`:**
  - Op-code localparams (base and M), with names matching the mnemonics above.
  - `alu_state_e` enum: IDLE/MUL/DIV/DONE.
  - `XLEN` legality check.
- **Sub-module `alu_div_iter`:** restoring divider.
  - Inputs: start, unsigned dividend and divisor.
  - Outputs: busy/done, quotient, remainder.
  - Counter width: $clog2(XLEN)+1.
- **Top level** owns the FSM, base ops, multiplier, sign fix-up and special cases.

## Test plan
1. **Reset and base op.** Reset deasserted; ADD `a`=7, `b`=0xFFFF_FFFF. Expect `out_valid` 1 cycle after accept and `result`=6. Then SRA `a`=0x8000_0000, `b`=0x21: `result`=0xC000_0000 (shamt 1).
2. **MUL family.** MULH −2 × 3 → 0xFFFF_FFFF. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU −1 × 0xFFFF_FFFF → 0xFFFF_FFFF. Each has latency 2.
3. **Signed division.** DIV −7 / 2 → 0xFFFF_FFFD (−3); REM −7 / 2 → 0xFFFF_FFFF (−1). Expect `out_valid` exactly 33 cycles after accept, with `in_ready`=0 throughout.
4. **Special cases.**
   - DIVU 5/0 → 0xFFFF_FFFF.
   - REM 5/0 → 5.
   - DIV 0x8000_0000/−1 → 0x8000_0000.
   - REM of the same → 0.
   - Each has latency 1.
5. **Backpressure.** Hold `out_ready`=0 for 10 cycles after a DIV completes: `result` stays stable and `in_ready`=0. Raise `out_ready`: `in_ready`=1 one cycle later.
6. **Abort mid-division.**
   - `flush` at iteration 10 of a DIV: `out_valid` never rises; `in_ready`=1 next cycle. A following ADD 1+1 → 2.
   - Repeat with `rst_n` asserted mid-DIV: outputs return to reset values immediately.
